// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage data-memory access unit. Turns a load/store in MEM into a single
//   req/ack bus transaction, stalls the pipeline while it is outstanding, and
//   returns extended load data. Misaligned accesses raise an address exception
//   without touching the bus. A BUSY phase that sees no ack for TIMEOUT cycles
//   is aborted with a one-cycle bus_err pulse.
//
// Ports
//   clk, reset               clock, asynchronous active-low reset
//   memwrite, M_load         store / load present in MEM (store wins if both)
//   BEop[1:0]                store size: 00 sw, 01 sb, 10 sh, 11 sw
//   LDop[2:0]                load type: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu
//   addr[31:0], wdata[31:0]  byte address and store data
//   bus_ack, bus_rdata       slave completion and read data
//   bus_req, bus_we, bus_be, bus_addr, bus_wdata   bus request side
//   stall                    holds IF/ID/EX/MEM
//   load_data, load_valid    extended load result and its one-cycle strobe
//   exc_adel, exc_ades       misaligned load / store
//   bus_err                  one-cycle timeout pulse
//   dbg_state_o              current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: bus_req rises in the cycle after the access is accepted and stays
// high, with bus_addr/bus_we/bus_be/bus_wdata frozen, until the first cycle in
// which bus_ack is sampled high (or the timeout fires); bus_ack is ignored in
// every other state.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic        M_load,
    input  logic [1:0]  BEop,
    input  logic [2:0]  LDop,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        bus_err,
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter value seen in the TIMEOUT-th BUSY cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        is_load_q, is_load_d;
    logic [2:0]  ldop_q, ldop_d;
    logic [1:0]  boff_q, boff_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] ldata_q, ldata_d;

    logic        access;
    logic        misaligned;
    logic        start;
    logic [3:0]  new_be;
    logic [31:0] new_wdata;
    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_data;

    // Decode of the instruction sitting in MEM.
    always_comb begin
        access     = memwrite | M_load;
        misaligned = 1'b0;
        new_be     = 4'b1111;
        new_wdata  = wdata;
        if (memwrite) begin
            case (BEop)
                2'b01: begin
                    new_be    = 4'b0001 << addr[1:0];
                    new_wdata = {4{wdata[7:0]}};
                end
                2'b10: begin
                    misaligned = addr[0];
                    new_be     = addr[1] ? 4'b1100 : 4'b0011;
                    new_wdata  = {2{wdata[15:0]}};
                end
                default: misaligned = |addr[1:0];
            endcase
        end else begin
            case (LDop)
                3'b001, 3'b010: misaligned = 1'b0;
                3'b011, 3'b100: misaligned = addr[0];
                default:        misaligned = |addr[1:0];
            endcase
        end
        start = (state_q == ST_IDLE) && access && !misaligned;
    end

    // Little-endian lane selection on the returned word, then extension.
    always_comb begin
        shifted  = bus_rdata >> {boff_q, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = boff_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (ldop_q)
            3'b001:  ext_data = {{24{byte_sel[7]}}, byte_sel};
            3'b010:  ext_data = {24'h0, byte_sel};
            3'b011:  ext_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  ext_data = {16'h0, half_sel};
            default: ext_data = bus_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        is_load_d = is_load_q;
        ldop_d    = ldop_q;
        boff_d    = boff_q;
        we_d      = we_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ldata_d   = ldata_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_BUSY;
                    cnt_d     = 8'd0;
                    err_d     = 1'b0;
                    is_load_d = !memwrite;
                    ldop_d    = LDop;
                    boff_d    = addr[1:0];
                    we_d      = memwrite;
                    be_d      = new_be;
                    addr_d    = {addr[31:2], 2'b00};
                    // Loads leave the last store data on the bus untouched.
                    if (memwrite) begin
                        wdata_d = new_wdata;
                    end
                end
            end
            ST_BUSY: begin
                // An ack in the final allowed cycle still completes normally.
                if (bus_ack) begin
                    if (is_load_q) begin
                        ldata_d = ext_data;
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
            is_load_q <= 1'b0;
            ldop_q    <= 3'b000;
            boff_q    <= 2'b00;
            we_q      <= 1'b0;
            be_q      <= 4'b0000;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            ldata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            is_load_q <= is_load_d;
            ldop_q    <= ldop_d;
            boff_q    <= boff_d;
            we_q      <= we_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ldata_q   <= ldata_d;
        end
    end

    // bus_req is decoded from the state register so an asynchronous reset
    // drops it immediately; stall is gated by reset for the same reason.
    assign bus_req     = (state_q == ST_BUSY);
    assign bus_we      = we_q;
    assign bus_be      = be_q;
    assign bus_addr    = addr_q;
    assign bus_wdata   = wdata_q;
    assign stall       = reset & (start | (state_q == ST_BUSY));
    assign bus_err     = (state_q == ST_DONE) & err_q;
    assign load_valid  = (state_q == ST_DONE) & is_load_q & !err_q;
    // The register keeps the last good load; a timed-out load shows zero.
    assign load_data   = bus_err ? 32'h0 : ldata_q;
    assign exc_adel    = (state_q == ST_IDLE) & access & !memwrite & misaligned;
    assign exc_ades    = (state_q == ST_IDLE) & memwrite & misaligned;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int TB_TIMEOUT = 4;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic        M_load;
  logic [1:0]  BEop;
  logic [2:0]  LDop;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        exc_adel;
  logic        exc_ades;
  logic        bus_err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  mem_access_unit #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .memwrite   (memwrite),
    .M_load     (M_load),
    .BEop       (BEop),
    .LDop       (LDop),
    .addr       (addr),
    .wdata      (wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_be     (bus_be),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .exc_adel   (exc_adel),
    .exc_ades   (exc_ades),
    .bus_err    (bus_err),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    int          sh;
    sh = int'(off);
    b  = w[sh*8 +: 8];
    h  = off[1] ? w[31:16] : w[15:0];
    case (op)
      3'b001:  return {{24{b[7]}}, b};
      3'b010:  return {24'h0, b};
      3'b011:  return {{16{h[15]}}, h};
      3'b100:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] beop, input logic [1:0] off);
    case (beop)
      2'b01:   return 4'b0001 << off;
      2'b10:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_wd(input logic [1:0] beop, input logic [31:0] wd);
    case (beop)
      2'b01:   return {4{wd[7:0]}};
      2'b10:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // ---------------- comparison ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (load_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_load_valid: observed data %h expected no pulse", load_data);
      end
      if (exp_q.size() > 0) check("sb_load_data", load_data, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    memwrite = 1'b0;
    M_load   = 1'b0;
    BEop     = 2'b00;
    LDop     = 3'b000;
    addr     = 32'h0;
    wdata    = 32'h0;
    bus_ack  = 1'b0;
  endtask

  // Aligned access; ack arrives in BUSY cycle ack_after+1, or never.
  task automatic run_access(input logic we, input logic ld, input logic [1:0] beop,
                            input logic [2:0] ldop, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int ack_after, input bit give_ack,
                            input logic [31:0] prev_ld);
    int   stalls;
    int   busy;
    bit   done;
    logic is_load;
    logic [3:0]  e_be;
    int   e_busy;
    is_load = ld && !we;
    e_be    = we ? model_be(beop, a[1:0]) : 4'b1111;
    e_busy  = give_ack ? ack_after + 1 : TB_TIMEOUT;
    if (is_load && give_ack) exp_q.push_back(model_load(ldop, a[1:0], rd));
    @(posedge clk); #1;
    memwrite  = we;
    M_load    = ld;
    BEop      = beop;
    LDop      = ldop;
    addr      = a;
    wdata     = wd;
    bus_ack   = 1'b0;
    bus_rdata = rd;
    stalls = 0;
    busy   = 0;
    done   = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (stall === 1'b1) stalls++;
      if (bus_req === 1'b1) begin
        busy++;
        check("bus_addr", bus_addr, {a[31:2], 2'b00});
        check("bus_we", 32'(bus_we), 32'(we));
        check("bus_be", 32'(bus_be), 32'(e_be));
        if (we) check("bus_wdata", bus_wdata, model_wd(beop, wd));
        bus_ack = give_ack && (busy == ack_after + 1);
      end else if (busy > 0) begin
        done     = 1;
        bus_ack  = 1'b0;
        memwrite = 1'b0;
        M_load   = 1'b0;
        check("done_stall", 32'(stall), 32'd0);
        check("done_load_valid", 32'(load_valid), 32'(is_load && give_ack));
        check("done_bus_err", 32'(bus_err), 32'(!give_ack));
        check("busy_cycles", 32'(busy), 32'(e_busy));
        check("stall_cycles", 32'(stalls), 32'(e_busy + 1));
        if (!give_ack) check("timeout_load_data", load_data, 32'h0);
        else if (!is_load) check("held_load_data", load_data, prev_ld);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL access_timeout: observed no DONE within bound expected completion");
      idle_inputs();
    end
    @(negedge clk);
    check("back_to_idle", 32'(dbg_state), 32'd0);
  endtask

  // Misaligned access: exception flag up, no stall, bus never requested.
  task automatic run_misaligned(input logic we, input logic [1:0] beop, input logic [2:0] ldop,
                                input logic [31:0] a);
    int reqs;
    @(posedge clk); #1;
    memwrite = we;
    M_load   = !we;
    BEop     = beop;
    LDop     = ldop;
    addr     = a;
    wdata    = 32'hCAFEF00D;
    reqs     = 0;
    @(negedge clk);
    check("exc_ades", 32'(exc_ades), 32'(we));
    check("exc_adel", 32'(exc_adel), 32'(!we));
    check("mis_stall", 32'(stall), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus_req !== 1'b0) reqs++;
    end
    check("mis_no_req", 32'(reqs), 32'd0);
    check("mis_state", 32'(dbg_state), 32'd0);
    idle_inputs();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] last_ld;
    int          busy;
    idle_inputs();
    bus_rdata = 32'h0;
    reset     = 1'b0;
    // Aligned load presented during reset must not stall.
    M_load = 1'b1;
    addr   = 32'h100;
    @(negedge clk);
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_bus_be", 32'(bus_be), 32'd0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_load_valid", 32'(load_valid), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    idle_inputs();
    reset = 1'b1;

    // Stray ack in IDLE is ignored.
    @(negedge clk);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    check("stray_ack_state", 32'(dbg_state), 32'd0);
    check("stray_ack_req", 32'(bus_req), 32'd0);

    // lw, ack in first BUSY cycle.
    run_access(1'b0, 1'b1, 2'b00, 3'b000, 32'h100, 32'h0, 32'h8899AABB, 0, 1'b1, 32'h0);
    // lb / lbu / lh sign and zero extension.
    run_access(1'b0, 1'b1, 2'b00, 3'b001, 32'h103, 32'h0, 32'h80FF0000, 0, 1'b1, 32'h0);
    run_access(1'b0, 1'b1, 2'b00, 3'b010, 32'h103, 32'h0, 32'h80FF0000, 1, 1'b1, 32'h0);
    run_access(1'b0, 1'b1, 2'b00, 3'b011, 32'h102, 32'h0, 32'h80FF0000, 0, 1'b1, 32'h0);
    run_access(1'b0, 1'b1, 2'b00, 3'b100, 32'h100, 32'h0, 32'h1234ABCD, 0, 1'b1, 32'h0);
    last_ld = 32'h0000ABCD;
    // sb with ack in the last allowed BUSY cycle: ack wins over timeout.
    run_access(1'b1, 1'b0, 2'b01, 3'b000, 32'h201, 32'h12345678, 32'h0, 3, 1'b1, last_ld);
    // sh upper half, sw, and store+load together (store wins).
    run_access(1'b1, 1'b0, 2'b10, 3'b000, 32'h202, 32'hDEADBEEF, 32'h0, 1, 1'b1, last_ld);
    run_access(1'b1, 1'b0, 2'b11, 3'b000, 32'h204, 32'h01020304, 32'h0, 0, 1'b1, last_ld);
    run_access(1'b1, 1'b1, 2'b00, 3'b001, 32'h010, 32'h55AA55AA, 32'hFFFFFFFF, 0, 1'b1, last_ld);

    // Misaligned accesses.
    run_misaligned(1'b1, 2'b00, 3'b000, 32'h202);
    run_misaligned(1'b0, 2'b00, 3'b011, 32'h101);
    run_misaligned(1'b0, 2'b00, 3'b000, 32'h102);

    // Timeout: lw with no ack.
    run_access(1'b0, 1'b1, 2'b00, 3'b000, 32'h300, 32'h0, 32'h11111111, 0, 1'b0, last_ld);
    @(negedge clk);
    check("post_timeout_load_data", load_data, last_ld);

    // Reset during BUSY.
    @(posedge clk); #1;
    M_load = 1'b1;
    LDop   = 3'b000;
    addr   = 32'h340;
    busy   = 0;
    for (int c = 0; c < 10 && busy < 2; c++) begin
      @(negedge clk);
      if (bus_req === 1'b1) busy++;
    end
    check("pre_rst_busy", 32'(busy), 32'd2);
    reset = 1'b0;
    #1;
    check("mid_rst_bus_req", 32'(bus_req), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_state", 32'(dbg_state), 32'd0);
    check("post_rst_bus_addr", bus_addr, 32'h0);
    check("post_rst_bus_err", 32'(bus_err), 32'd0);
    run_access(1'b0, 1'b1, 2'b00, 3'b000, 32'h400, 32'h0, 32'hA5A5F00F, 1, 1'b1, 32'h0);

    // Randomised aligned loads.
    for (int i = 0; i < 6; i++) begin
      logic [2:0]  op;
      logic [1:0]  off;
      logic [31:0] a;
      op  = 3'($urandom_range(0, 4));
      off = 2'($urandom_range(0, 3));
      if (op == 3'b011 || op == 3'b100) off[0] = 1'b0;
      if (op == 3'b000) off = 2'b00;
      a = {22'h0, 8'($urandom_range(0, 255)), off};
      run_access(1'b0, 1'b1, 2'b00, op, a, 32'h0, $urandom, $urandom_range(0, 2), 1'b1, 32'h0);
    end

    @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
